alu_issue_ctrl: RTL

//  Initiator side of the ALU operand/result interface. Accepts one operation per valid/ready handshake,

---
 rtl/alu_issue_ctrl_pkg.sv | 39 +++
 rtl/alu_op_decode.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: 5-bit opcode encodings,
// writeback select codes, wait-counter width and the controller FSM states.
// The same opcode set is used by the ALU behind this block.
package alu_issue_ctrl_pkg;

  localparam logic [4:0] OP_LOAD = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_SHLA = 5'b10011;

  localparam logic [1:0] WB_SEL_GPR = 2'd0;
  localparam logic [1:0] WB_SEL_LO  = 2'd1;
  localparam logic [1:0] WB_SEL_HI  = 2'd2;

  // Width of the EXEC wait counter; bounds MUL_WAIT / DIV_WAIT to 255.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB_LO,
    ST_WB_HI
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder for the ALU issue controller.
// Ports:
//   i_op        request opcode
//   o_legal     opcode belongs to the supported set
//   o_is_wide   MUL or DIV (two writeback beats, LO then HI)
//   o_wait_cnt  extra EXEC cycles before result capture
//   o_op        opcode driven to the ALU (immediate forms folded onto register forms)
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 1,
  parameter int unsigned DIV_WAIT = 0
) (
  input  logic [4:0]       i_op,
  output logic             o_legal,
  output logic             o_is_wide,
  output logic [CNT_W-1:0] o_wait_cnt,
  output logic [4:0]       o_op
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_WAIT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_WAIT);

  always_comb begin
    o_legal    = 1'b1;
    o_is_wide  = 1'b0;
    o_wait_cnt = '0;
    o_op       = i_op;
    case (i_op)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
      OP_SHRA, OP_SHL, OP_NEG, OP_NOT, OP_SHLA: ;
      OP_ADDI: o_op = OP_ADD;
      OP_ANDI: o_op = OP_AND;
      OP_ORI:  o_op = OP_OR;
      OP_MUL: begin
        o_is_wide  = 1'b1;
        o_wait_cnt = MUL_CNT;
      end
      OP_DIV: begin
        o_is_wide  = 1'b1;
        o_wait_cnt = DIV_CNT;
      end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU operand/result interface. Accepts one operation
// per valid/ready handshake, drives registered operands/opcode into the ALU,
// waits the per-op latency, captures ResultHi/ResultLo into Z registers and
// sequences writeback beats (GPR, or LO then HI for MUL/DIV).
// Ports:
//   clock, clear                       clock and synchronous active-high reset
//   req_valid/req_ready                request handshake (ready only in IDLE)
//   req_op/req_ra/req_rb/req_rd        request opcode, operands, destination
//   alu_ra/alu_rb/alu_op               registered ALU inputs
//   alu_hi/alu_lo                      ALU results
//   wb_valid/wb_sel/wb_addr/wb_data    writeback beat (consumer always accepts)
//   err                                one-cycle pulse for a dropped illegal opcode
//   busy                               ~req_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 1,
  parameter int unsigned DIV_WAIT = 0,
  parameter int unsigned RD_W     = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [31:0]     req_ra,
  input  logic [31:0]     req_rb,
  input  logic [RD_W-1:0] req_rd,
  output logic [31:0]     alu_ra,
  output logic [31:0]     alu_rb,
  output logic [4:0]      alu_op,
  input  logic [31:0]     alu_hi,
  input  logic [31:0]     alu_lo,
  output logic            wb_valid,
  output logic [1:0]      wb_sel,
  output logic [RD_W-1:0] wb_addr,
  output logic [31:0]     wb_data,
  output logic            err,
  output logic            busy
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ra;
  logic [31:0]      r_rb;
  logic [4:0]       r_op;
  logic [RD_W-1:0]  r_rd;
  logic             r_wide;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_z_hi;
  logic [31:0]      r_z_lo;
  logic             r_err;

  logic             w_legal;
  logic             w_is_wide;
  logic [CNT_W-1:0] w_wait_cnt;
  logic [4:0]       w_op;

  alu_op_decode #(
    .MUL_WAIT (MUL_WAIT),
    .DIV_WAIT (DIV_WAIT)
  ) u_decode (
    .i_op       (req_op),
    .o_legal    (w_legal),
    .o_is_wide  (w_is_wide),
    .o_wait_cnt (w_wait_cnt),
    .o_op       (w_op)
  );

  // State register
  always_ff @(posedge clock) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid && w_legal) w_next = ST_EXEC;
      ST_EXEC:  if (r_cnt == '0) w_next = ST_WB_LO;
      ST_WB_LO: w_next = r_wide ? ST_WB_HI : ST_IDLE;
      ST_WB_HI: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand, wait-counter, Z and error registers. Operands change only on
  // accept and Z only on capture, so both hold across the writeback beats.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_op   <= OP_LOAD;
      r_rd   <= '0;
      r_wide <= 1'b0;
      r_cnt  <= '0;
      r_z_hi <= '0;
      r_z_lo <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_legal) begin
              r_ra   <= req_ra;
              r_rb   <= req_rb;
              r_op   <= w_op;
              r_rd   <= req_rd;
              r_wide <= w_is_wide;
              r_cnt  <= w_wait_cnt;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_z_hi <= alu_hi;
            r_z_lo <= alu_lo;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    req_ready = 1'b0;
    wb_valid  = 1'b0;
    wb_sel    = WB_SEL_GPR;
    wb_addr   = '0;
    wb_data   = '0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_WB_LO: begin
        wb_valid = 1'b1;
        wb_data  = r_z_lo;
        if (r_wide) begin
          wb_sel = WB_SEL_LO;
        end else begin
          wb_sel  = WB_SEL_GPR;
          wb_addr = r_rd;
        end
      end
      ST_WB_HI: begin
        wb_valid = 1'b1;
        wb_sel   = WB_SEL_HI;
        wb_data  = r_z_hi;
      end
      default: ;
    endcase
  end

  assign busy   = ~req_ready;
  assign err    = r_err;
  assign alu_ra = r_ra;
  assign alu_rb = r_rb;
  assign alu_op = r_op;

endmodule
